// File: rtl/paddle_ai.sv
// Paddle AI: rests the paddle near CENTER_X while the ball recedes, waits a
// reaction delay when the ball turns toward us, then tracks the ball. Move
// requests (up/down) are registered and rate-limited by a strobe counter.
//
// Handshake note: there is no valid/ready pair. up/down are single-cycle
// level requests sampled by the paddle mover on every rising clock edge;
// a request is "accepted" simply by being present in that cycle.
module paddle_ai #(
  parameter logic [7:0] HEIGTH      = 8'd40,
  parameter logic [7:0] MAX_X       = 8'd239,
  parameter logic [7:0] MIN_X       = 8'd0,
  parameter logic [7:0] CENTER_X    = 8'd119,
  parameter int         DEAD_ZONE   = 3,
  parameter int         REACT_DELAY = 15,
  parameter int         STEP_DIV    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ball_x,
  input  logic       ball_toward,
  input  logic [7:0] paddle_x,
  output logic       up,
  output logic       down,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECENTER = 2'd1,
    REACT    = 2'd2,
    TRACK    = 2'd3
  } state_t;

  localparam logic signed [9:0] DZ_POS     = 10'(DEAD_ZONE);
  localparam logic signed [9:0] DZ_NEG     = -DZ_POS;
  localparam logic [7:0]        STEP_MAX   = 8'(STEP_DIV - 1);
  localparam logic [7:0]        DELAY_LOAD = 8'(REACT_DELAY);

  state_t      state_q, state_d;
  logic [7:0]  delay_q, delay_d;
  logic [7:0]  strobe_cnt_q, strobe_cnt_d;
  logic        up_q, up_d;
  logic        down_q, down_d;

  logic              strobe;
  logic              active;
  logic [7:0]        target;
  logic [8:0]        center;
  logic [8:0]        top_edge;
  logic signed [9:0] err;
  logic              want_up;
  logic              want_down;

  assign up    = up_q;
  assign down  = down_q;
  assign state = state_q;

  // Next-state logic; enable=0 overrides every other transition.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    case (state_q)
      IDLE: begin
        state_d = RECENTER;
      end
      RECENTER: begin
        if (ball_toward) begin
          state_d = REACT;
          delay_d = DELAY_LOAD;
        end
      end
      REACT: begin
        // Ball turning away beats delay expiry.
        if (!ball_toward) begin
          state_d = RECENTER;
        end else if (delay_q == 8'd0) begin
          state_d = TRACK;
        end else begin
          delay_d = delay_q - 8'd1;
        end
      end
      TRACK: begin
        if (!ball_toward) begin
          state_d = RECENTER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
    end
  end

  // Strobe counter: wraps 0..STEP_DIV-1 while active, parked at 0 in IDLE.
  always_comb begin
    strobe = (strobe_cnt_q == STEP_MAX);
    if (state_q == IDLE) begin
      strobe_cnt_d = 8'd0;
    end else if (strobe) begin
      strobe_cnt_d = 8'd0;
    end else begin
      strobe_cnt_d = strobe_cnt_q + 8'd1;
    end
  end

  // Move decision: error against the target with dead zone and edge limits.
  always_comb begin
    target = 8'd0;
    active = 1'b0;
    case (state_q)
      RECENTER: begin
        target = CENTER_X;
        active = 1'b1;
      end
      TRACK: begin
        target = ball_x;
        active = 1'b1;
      end
      default: begin
        target = 8'd0;
        active = 1'b0;
      end
    endcase
    center    = {1'b0, paddle_x} + {1'b0, (HEIGTH >> 1)};
    top_edge  = {1'b0, paddle_x} + {1'b0, HEIGTH};
    err       = $signed({2'b00, target}) - $signed({1'b0, center});
    want_up   = active && (err > DZ_POS) && (top_edge < {1'b0, MAX_X});
    want_down = active && (err < DZ_NEG) && (paddle_x > MIN_X);
    // Gating with enable keeps outputs quiet in the same edge the FSM drops
    // to IDLE, so a disable never leaks a stale request.
    up_d      = enable && strobe && want_up;
    down_d    = enable && strobe && want_down;
  end

  // State, counters and registered move requests; synchronous reset wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      delay_q      <= 8'd0;
      strobe_cnt_q <= 8'd0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      strobe_cnt_q <= strobe_cnt_d;
      up_q         <= up_d;
      down_q       <= down_d;
    end
  end

endmodule
